// File: rtl/rx_sm.sv
// Receive MAC state machine: strips preamble/SFD, checks FCS and length, and writes frames
// into the RX FIFO. Optional ADDRESS_FILTER_EN build drops frames not addressed to us.
module rx_sm #(
  parameter int unsigned MIN_FRAME = 64,
  parameter int unsigned MAX_FRAME = 1518
`ifdef ADDRESS_FILTER_EN
  ,
  parameter logic [47:0] MAC_ADDR  = 48'h00_0A_35_00_00_01
`endif
) (
  input  logic       reset,
  input  logic       clock,
  input  logic [7:0] rx_data,
  input  logic       rx_data_valid,
  input  logic       rx_error,
  input  logic       fifo_full,
  output logic [7:0] fifo_data,
  output logic       fifo_data_write,
  output logic       fifo_data_start,
  output logic       fifo_data_end,
  output logic       fifo_data_error,
  output logic       fifo_rewind,
  output logic       frame_good,
  output logic       frame_bad
);

  // Bytes are held back until the destination address decides whether the frame is kept.
`ifdef ADDRESS_FILTER_EN
  localparam int unsigned Depth = 7;
`else
  localparam int unsigned Depth = 1;
`endif
  localparam int unsigned CntW       = $clog2(Depth + 1);
  localparam logic [31:0] CrcResidue = 32'hC704DD7B;
  localparam logic [10:0] LenSat     = 11'h7FF;
  localparam logic [10:0] MinLen     = 11'(MIN_FRAME);
  localparam logic [10:0] MaxLen     = 11'(MAX_FRAME);

  typedef enum logic [2:0] {StIdle, StPreamble, StData, StDrop, StDone} state_e;

  state_e                  state_q, state_d;
  logic [31:0]             crc_q, crc_d;
  logic [10:0]             len_q, len_d;
  logic                    err_q, err_d;
  logic                    first_q, first_d;
  logic                    ended_q, ended_d;
  logic                    bad_q, bad_d;
  logic                    silent_q, silent_d;
  logic [Depth-1:0][7:0]   pipe_q, pipe_d;
  logic [CntW-1:0]         cnt_q, cnt_d;

  logic [7:0] data_q, data_d;
  logic       write_q, write_d;
  logic       start_q, start_d;
  logic       end_q, end_d;
  logic       error_q, error_d;
  logic       rewind_q, rewind_d;
  logic       good_q, good_d;
  logic       fbad_q, fbad_d;

  logic       wr_req;
  logic       wr_last;
  logic [7:0] wr_byte;

`ifdef ADDRESS_FILTER_EN
  logic [47:0] addr_q, addr_d;
  logic [47:0] da_now;
  assign da_now = {addr_q[39:0], rx_data};
`endif

  // Ethernet CRC-32, MSB-first register, data bits consumed LSB first.
  function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if (c[31] ^ data[i]) c = {c[30:0], 1'b0} ^ 32'h04C11DB7;
      else                 c = {c[30:0], 1'b0};
    end
    return c;
  endfunction

  always_comb begin
    state_d  = state_q;
    crc_d    = crc_q;
    len_d    = len_q;
    err_d    = err_q;
    first_d  = first_q;
    ended_d  = ended_q;
    bad_d    = bad_q;
    silent_d = silent_q;
    pipe_d   = pipe_q;
    cnt_d    = cnt_q;
    data_d   = data_q;
    write_d  = 1'b0;
    start_d  = 1'b0;
    end_d    = 1'b0;
    error_d  = 1'b0;
    rewind_d = 1'b0;
    good_d   = 1'b0;
    fbad_d   = 1'b0;
    wr_req   = 1'b0;
    wr_last  = 1'b0;
    wr_byte  = 8'h00;
`ifdef ADDRESS_FILTER_EN
    addr_d   = addr_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (rx_data_valid && rx_data == 8'h55) state_d = StPreamble;
      end
      StPreamble: begin
        if (rx_data_valid && rx_data == 8'hD5) begin
          state_d  = StData;
          crc_d    = '1;
          len_d    = '0;
          err_d    = 1'b0;
          first_d  = 1'b1;
          ended_d  = 1'b0;
          bad_d    = 1'b0;
          silent_d = 1'b0;
          cnt_d    = '0;
        end else if (!(rx_data_valid && rx_data == 8'h55)) begin
          state_d = StIdle;
        end
      end
      StData: begin
        if (ended_q || !rx_data_valid) begin
          // Frame input finished: verdict is fixed now, then the held bytes drain out.
          if (!ended_q) begin
            bad_d   = err_q | (crc_q != CrcResidue) | (len_q < MinLen) | (len_q > MaxLen);
            ended_d = 1'b1;
          end
          if (cnt_q == '0) begin
            state_d = StDone;
            bad_d   = 1'b1;
          end else begin
            wr_req  = 1'b1;
            wr_byte = pipe_q[cnt_q - 1'b1];
            wr_last = (cnt_q == CntW'(1));
            cnt_d   = cnt_q - 1'b1;
          end
        end else begin
          crc_d = crc_byte(crc_q, rx_data);
          if (len_q != LenSat) len_d = len_q + 11'd1;
          if (rx_error) err_d = 1'b1;
          if (cnt_q == CntW'(Depth)) begin
            wr_req  = 1'b1;
            wr_byte = pipe_q[Depth-1];
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
          pipe_d[0] = rx_data;
          for (int i = 1; i < Depth; i++) pipe_d[i] = pipe_q[i-1];
`ifdef ADDRESS_FILTER_EN
          if (len_q < 11'd6) addr_d = da_now;
          if (len_q == 11'd5 && da_now != MAC_ADDR && da_now != '1) begin
            state_d  = StDrop;
            silent_d = 1'b1;
          end
`endif
        end
        if (wr_req) begin
          if (fifo_full) begin
            rewind_d = 1'b1;
            state_d  = StDrop;
          end else begin
            write_d = 1'b1;
            data_d  = wr_byte;
            start_d = first_q;
            first_d = 1'b0;
            if (wr_last) begin
              end_d   = 1'b1;
              error_d = bad_d;
              state_d = StDone;
            end
          end
        end
      end
      StDrop: begin
        if (!rx_data_valid) begin
          fbad_d  = !silent_q;
          state_d = StIdle;
        end
      end
      StDone: begin
        good_d  = !bad_q;
        fbad_d  = bad_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      crc_q    <= '1;
      len_q    <= '0;
      err_q    <= 1'b0;
      first_q  <= 1'b0;
      ended_q  <= 1'b0;
      bad_q    <= 1'b0;
      silent_q <= 1'b0;
      pipe_q   <= '0;
      cnt_q    <= '0;
      data_q   <= '0;
      write_q  <= 1'b0;
      start_q  <= 1'b0;
      end_q    <= 1'b0;
      error_q  <= 1'b0;
      rewind_q <= 1'b0;
      good_q   <= 1'b0;
      fbad_q   <= 1'b0;
`ifdef ADDRESS_FILTER_EN
      addr_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      crc_q    <= crc_d;
      len_q    <= len_d;
      err_q    <= err_d;
      first_q  <= first_d;
      ended_q  <= ended_d;
      bad_q    <= bad_d;
      silent_q <= silent_d;
      pipe_q   <= pipe_d;
      cnt_q    <= cnt_d;
      data_q   <= data_d;
      write_q  <= write_d;
      start_q  <= start_d;
      end_q    <= end_d;
      error_q  <= error_d;
      rewind_q <= rewind_d;
      good_q   <= good_d;
      fbad_q   <= fbad_d;
`ifdef ADDRESS_FILTER_EN
      addr_q   <= addr_d;
`endif
    end
  end

  assign fifo_data       = data_q;
  assign fifo_data_write = write_q;
  assign fifo_data_start = start_q;
  assign fifo_data_end   = end_q;
  assign fifo_data_error = error_q;
  assign fifo_rewind     = rewind_q;
  assign frame_good      = good_q;
  assign frame_bad       = fbad_q;

endmodule

// File: tb/tb_rx_sm.sv
// Bench for rx_sm: random frames checked against a frame-level reference model
// (reflected CRC-32, length/error/full rules); honours ADDRESS_FILTER_EN.
module tb_rx_sm;

`ifdef ADDRESS_FILTER_EN
  localparam int Lat    = 7;
  localparam bit Filter = 1'b1;
`else
  localparam int Lat    = 1;
  localparam bit Filter = 1'b0;
`endif
  localparam logic [47:0] StationAddr = 48'h00_0A_35_00_00_01;

  typedef logic [7:0] bq_t[$];
  typedef struct packed {
    logic [7:0] data;
    logic       start;
    logic       last;
    logic       err;
  } wr_t;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_data_valid, rx_error, fifo_full;
  logic [7:0] fifo_data;
  logic       fifo_data_write, fifo_data_start, fifo_data_end, fifo_data_error;
  logic       fifo_rewind, frame_good, frame_bad;

  rx_sm dut (
    .reset          (reset),
    .clock          (clock),
    .rx_data        (rx_data),
    .rx_data_valid  (rx_data_valid),
    .rx_error       (rx_error),
    .fifo_full      (fifo_full),
    .fifo_data      (fifo_data),
    .fifo_data_write(fifo_data_write),
    .fifo_data_start(fifo_data_start),
    .fifo_data_end  (fifo_data_end),
    .fifo_data_error(fifo_data_error),
    .fifo_rewind    (fifo_rewind),
    .frame_good     (frame_good),
    .frame_bad      (frame_bad)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Output monitor, sampled on the falling edge.
  wr_t wr_q[$];
  int  n_rewind = 0, n_good = 0, n_fbad = 0;
  always @(negedge clock) begin
    if (!reset) begin
      if (fifo_data_write)
        wr_q.push_back({fifo_data, fifo_data_start, fifo_data_end, fifo_data_error});
      if (fifo_rewind) n_rewind++;
      if (frame_good)  n_good++;
      if (frame_bad)   n_fbad++;
    end
  end

  function automatic logic [31:0] crc_refl(input bq_t b);
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    foreach (b[i]) begin
      c = c ^ {24'h0, b[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    return c;
  endfunction

  task automatic drive(input logic dv, input logic [7:0] d, input logic er, input logic full);
    @(posedge clock);
    #1;
    rx_data_valid = dv;
    rx_data       = d;
    rx_error      = er;
    fifo_full     = full;
  endtask

  // da_mode: 0 random, 1 broadcast, 2 station, 3 other unicast
  task automatic build(input int n, input int da_mode, input bit flip, output bq_t f);
    logic [31:0] c;
    logic [47:0] da;
    int          body, idx;
    f    = {};
    body = (n >= 4) ? n - 4 : n;
    for (int i = 0; i < body; i++) f.push_back(8'($urandom));
    case (da_mode)
      1:       da = '1;
      2:       da = StationAddr;
      3:       da = 48'h02_00_00_00_00_99;
      default: da = {16'($urandom), 32'($urandom)};
    endcase
    for (int i = 0; i < 6 && i < body; i++) f[i] = da[47-8*i -: 8];
    if (n >= 4) begin
      c = ~crc_refl(f);
      for (int i = 0; i < 4; i++) f.push_back(c[8*i +: 8]);
    end
    if (flip && n > 0) begin
      idx    = (n > 10) ? int'($urandom_range(n - 1, 6)) : int'($urandom_range(n - 1, 0));
      f[idx] = f[idx] ^ (8'h01 << $urandom_range(7, 0));
    end
  endtask

  task automatic run_frame(input string tag, input bq_t f, input int err_at, input int full_at,
                           input int pre_len);
    int n, wbase, rbase, gbase, bbase, exp_n, first_block, got_n, n_start, n_end;
    bit exp_bad, addr_ok, dropped, normal;
    logic [47:0] da;
    n     = f.size();
    wbase = wr_q.size();
    rbase = n_rewind;
    gbase = n_good;
    bbase = n_fbad;

    for (int i = 0; i < pre_len; i++) drive(1'b1, 8'h55, 1'b0, 1'($urandom));
    drive(1'b1, 8'hD5, 1'b0, 1'($urandom));
    for (int i = 0; i < n; i++)
      drive(1'b1, f[i], 1'(i == err_at), 1'(full_at >= 0 && i >= full_at));
    for (int i = 0; i < 16; i++) drive(1'b0, 8'($urandom), 1'($urandom), 1'b0);

    // Reference verdict
    exp_bad = (err_at >= 0 && err_at < n) || (crc_refl(f) != 32'hDEBB_20E3) || n < 64 ||
              n > 1518;
    addr_ok = 1'b1;
    if (Filter && n >= 6) begin
      for (int i = 0; i < 6; i++) da[47-8*i -: 8] = f[i];
      addr_ok = (da == StationAddr) || (da == '1);
    end
    first_block = (full_at > Lat) ? full_at : Lat;
    dropped     = addr_ok && full_at >= 0 && first_block < n;
    normal      = addr_ok && !dropped;
    exp_n       = !addr_ok ? 0 : (dropped ? first_block - Lat : n);

    got_n = wr_q.size() - wbase;
    check({tag, " nwr"}, got_n, exp_n);
    n_start = 0;
    n_end   = 0;
    for (int i = 0; i < got_n; i++) begin
      if (wr_q[wbase+i].start) n_start++;
      if (wr_q[wbase+i].last)  n_end++;
    end
    for (int i = 0; i < got_n && i < exp_n; i++) begin
      check($sformatf("%s byte%0d", tag, i), wr_q[wbase+i].data, f[i]);
      if (wr_q[wbase+i].data !== f[i]) break;
    end
    check({tag, " starts"}, n_start, (exp_n > 0) ? 1 : 0);
    if (got_n > 0 && exp_n > 0) check({tag, " first_start"}, wr_q[wbase].start, 1);
    check({tag, " ends"}, n_end, (normal && n > 0) ? 1 : 0);
    if (got_n > 0 && normal && n > 0) begin
      check({tag, " last_end"}, wr_q[wbase+got_n-1].last, 1);
      check({tag, " end_err"}, wr_q[wbase+got_n-1].err, exp_bad);
    end
    check({tag, " rewind"}, n_rewind - rbase, dropped ? 1 : 0);
    check({tag, " good"}, n_good - gbase, (normal && !exp_bad) ? 1 : 0);
    check({tag, " bad"}, n_fbad - bbase, (dropped || (normal && exp_bad)) ? 1 : 0);
  endtask

  initial begin
    bq_t f;
    int  n, rbase, gbase, bbase, wbase;

    reset         = 1'b1;
    rx_data       = 8'h00;
    rx_data_valid = 1'b0;
    rx_error      = 1'b0;
    fifo_full     = 1'b0;
    #12;
    check("rst write", fifo_data_write, 0);
    check("rst data", fifo_data, 0);
    check("rst pulses", {fifo_data_start, fifo_data_end, fifo_data_error, fifo_rewind,
                         frame_good, frame_bad}, 0);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) drive(1'b0, 8'h00, 1'b0, 1'b0);

    build(64, 1, 1'b0, f);   run_frame("good64", f, -1, -1, 7);
    build(64, 1, 1'b1, f);   run_frame("flip64", f, -1, -1, 7);
    build(60, 1, 1'b0, f);   run_frame("runt60", f, -1, -1, 7);
    build(100, 1, 1'b0, f);  run_frame("rxerr100", f, 20, -1, 7);
    build(100, 1, 1'b0, f);  run_frame("full100", f, -1, 30, 7);
    build(0, 1, 1'b0, f);    run_frame("len0", f, -1, -1, 3);
    build(1518, 1, 1'b0, f); run_frame("max1518", f, -1, -1, 7);
    build(1519, 1, 1'b0, f); run_frame("long1519", f, -1, -1, 7);
`ifdef ADDRESS_FILTER_EN
    build(80, 3, 1'b0, f);   run_frame("unicast_other", f, -1, -1, 7);
    build(80, 2, 1'b0, f);   run_frame("unicast_own", f, -1, -1, 7);
`endif

    // Broken preamble: no FIFO activity and no pulses.
    wbase = wr_q.size();
    gbase = n_good;
    bbase = n_fbad;
    drive(1'b1, 8'h55, 1'b0, 1'b0);
    drive(1'b1, 8'h55, 1'b0, 1'b0);
    drive(1'b1, 8'h12, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) drive(1'b1, 8'($urandom_range(8'h54, 8'h00)), 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) drive(1'b0, 8'h00, 1'b0, 1'b0);
    check("badpre nwr", wr_q.size() - wbase, 0);
    check("badpre pulses", (n_good - gbase) + (n_fbad - bbase), 0);

    for (int k = 0; k < 25; k++) begin
      int err_at, full_at;
      n       = ($urandom_range(3, 0) == 0) ? int'($urandom_range(12, 0))
                                            : int'($urandom_range(140, 60));
      err_at  = ($urandom_range(4, 0) == 0) ? int'($urandom_range(n, 0)) : -1;
      full_at = ($urandom_range(4, 0) == 0) ? int'($urandom_range(n, 0)) : -1;
      build(n, int'($urandom_range(3, 0)), 1'($urandom_range(3, 0) == 0), f);
      run_frame($sformatf("rnd%0d", k), f, err_at, full_at, int'($urandom_range(7, 1)));
    end

    // Reset in the middle of a frame abandons it without rewind or pulses.
    build(100, 1, 1'b0, f);
    rbase = n_rewind;
    gbase = n_good;
    bbase = n_fbad;
    for (int i = 0; i < 7; i++) drive(1'b1, 8'h55, 1'b0, 1'b0);
    drive(1'b1, 8'hD5, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) drive(1'b1, f[i], 1'b0, 1'b0);
    @(posedge clock);
    #1;
    reset         = 1'b1;
    rx_data_valid = 1'b0;
    #2;
    check("midrst write", fifo_data_write, 0);
    for (int i = 0; i < 2; i++) drive(1'b0, 8'h00, 1'b0, 1'b0);
    reset = 1'b0;
    for (int i = 0; i < 16; i++) drive(1'b0, 8'h00, 1'b0, 1'b0);
    check("midrst rewind", n_rewind - rbase, 0);
    check("midrst pulses", (n_good - gbase) + (n_fbad - bbase), 0);
    build(70, 1, 1'b0, f);
    run_frame("after_rst", f, -1, -1, 7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
